// File: rtl/demux4_router.sv
// ---------------------------------------------------------------------------
// demux4_router
//
// Steers one WIDTH-bit producer stream to one of two sinks. in_sel=1 selects
// sink A and in_sel=0 selects sink B. Each sink has its own DEPTH-entry FIFO
// with a valid/ready handshake, so a stalled sink never holds back the other
// sink's buffered words. Each sink also keeps a count of delivered words for
// debug.
//
// Ports:
//   clk       system clock; all state changes on the rising edge
//   rst_n     synchronous active-low reset
//   in_valid  producer has a word on in_data
//   in_ready  router accepts the word for the currently selected sink
//   in_data   word to route
//   in_sel    destination select (1 = A, 0 = B)
//   a_valid   FIFO A non-empty          b_valid   FIFO B non-empty
//   a_ready   sink A takes the head     b_ready   sink B takes the head
//   a_data    head of FIFO A            b_data    head of FIFO B
//   a_full    FIFO A holds DEPTH words  b_full    FIFO B holds DEPTH words
//   a_count   words delivered on A      b_count   words delivered on B
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// demux4_router_fifo
//
// One output lane: a DEPTH-entry circular buffer with a separate occupancy
// counter and a wrapping delivered-word counter.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   push_i      write data_i at the tail (ignored when full)
//   data_i      word to append
//   ready_i     sink accepts the head word this cycle
//   valid_o     buffer non-empty
//   data_o      head entry, read straight from storage
//   full_o      buffer holds DEPTH words
//   count_o     number of words popped, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module demux4_router_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] OccFull = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      occ_q, occ_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign valid_o = (occ_q != '0);
    assign full_o  = (occ_q == OccFull);
    assign data_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    // The full check is repeated here so the lane can never overwrite a
    // buffered word, whatever the caller does with push_i.
    assign doPush = push_i && !full_o;
    assign doPop  = valid_o && ready_i;

    // Next-state for pointers, occupancy and the delivered counter. A push
    // and a pop in the same cycle leave occupancy unchanged while both
    // pointers advance.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        occ_d   = occ_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + AW'(1);
            count_d = count_q + CNT_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State and storage registers. Reset clears the storage too, so the
    // data output reads zero straight after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            occ_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            occ_q   <= occ_d;
            count_q <= count_d;
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
            end
        end
    end

endmodule

module demux4_router #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             a_full,
    output logic             b_full,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic pushA;
    logic pushB;

    // in_ready looks only at the registered full flag of the selected lane,
    // never at the sink readies, so there is no combinational path from a
    // sink back to the producer. A full lane therefore refuses a push even
    // in a cycle where it is also being popped.
    assign in_ready = in_sel ? !a_full : !b_full;
    assign pushA    = in_valid && in_ready && in_sel;
    assign pushB    = in_valid && in_ready && !in_sel;

    demux4_router_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) laneA (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pushA),
        .data_i  (in_data),
        .ready_i (a_ready),
        .valid_o (a_valid),
        .data_o  (a_data),
        .full_o  (a_full),
        .count_o (a_count)
    );

    demux4_router_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) laneB (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pushB),
        .data_i  (in_data),
        .ready_i (b_ready),
        .valid_o (b_valid),
        .data_o  (b_data),
        .full_o  (b_full),
        .count_o (b_count)
    );

endmodule

// File: tb/tb_demux4_router.sv
// ---------------------------------------------------------------------------
// tb_demux4_router
//
// Drives demux4_router through a table of directed cycles, a counter-wrap
// sequence and a randomized phase. A queue-based reference model tracks
// what each sink should see.
// ---------------------------------------------------------------------------
module tb_demux4_router;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic             a_full;
    logic             b_full;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    int nCompared   = 0;
    int nMismatched = 0;

    demux4_router #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_full   (a_full),
        .b_full   (b_full),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One directed cycle: inputs applied before the edge, in_ready expected
    // before the edge, everything else expected after it.
    typedef struct {
        logic             rstN;
        logic             inValid;
        logic             inSel;
        logic [WIDTH-1:0] inData;
        logic             aReady;
        logic             bReady;
        logic             expInReady;
        logic             expAValid;
        logic [WIDTH-1:0] expAData;
        logic             expAFull;
        logic [CNT_W-1:0] expACount;
        logic             expBValid;
        logic [WIDTH-1:0] expBData;
        logic             expBFull;
        logic [CNT_W-1:0] expBCount;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t mkVec(input int rstN, input int v, input int s, input int d,
                                   input int ar, input int br, input int ir,
                                   input int av, input int ad, input int af, input int ac,
                                   input int bv, input int bd, input int bf, input int bc);
        vec_t r;
        r.rstN       = 1'(rstN);
        r.inValid    = 1'(v);
        r.inSel      = 1'(s);
        r.inData     = WIDTH'(d);
        r.aReady     = 1'(ar);
        r.bReady     = 1'(br);
        r.expInReady = 1'(ir);
        r.expAValid  = 1'(av);
        r.expAData   = WIDTH'(ad);
        r.expAFull   = 1'(af);
        r.expACount  = CNT_W'(ac);
        r.expBValid  = 1'(bv);
        r.expBData   = WIDTH'(bd);
        r.expBFull   = 1'(bf);
        r.expBCount  = CNT_W'(bc);
        return r;
    endfunction

    // Reference model: one queue per sink plus plain integer counters,
    // advanced on every rising edge from the handshake rules.
    logic [WIDTH-1:0] modelA[$];
    logic [WIDTH-1:0] modelB[$];
    int               modelACount = 0;
    int               modelBCount = 0;

    always @(posedge clk) begin
        bit accept;
        bit popA;
        bit popB;
        if (!rst_n) begin
            modelA.delete();
            modelB.delete();
            modelACount = 0;
            modelBCount = 0;
        end else begin
            accept = in_valid && (in_sel ? (modelA.size() < DEPTH) : (modelB.size() < DEPTH));
            popA   = (modelA.size() != 0) && a_ready;
            popB   = (modelB.size() != 0) && b_ready;
            if (popA) begin
                void'(modelA.pop_front());
                modelACount = (modelACount + 1) % (1 << CNT_W);
            end
            if (popB) begin
                void'(modelB.pop_front());
                modelBCount = (modelBCount + 1) % (1 << CNT_W);
            end
            if (accept) begin
                if (in_sel) modelA.push_back(in_data);
                else        modelB.push_back(in_data);
            end
        end
    end

    // Every falling edge compares the DUT with the model, and checks that a
    // head word held back by its sink stays put across the next edge.
    logic             holdA = 1'b0;
    logic             holdB = 1'b0;
    logic [WIDTH-1:0] heldA = '0;
    logic [WIDTH-1:0] heldB = '0;
    logic             modelEnable = 1'b0;

    always @(negedge clk) begin
        if (modelEnable) begin
            checkOutput("mdl_in_ready", 32'(in_ready),
                        (in_sel ? (modelA.size() < DEPTH) : (modelB.size() < DEPTH)) ? 1 : 0);
            checkOutput("mdl_a_valid", 32'(a_valid), (modelA.size() != 0) ? 1 : 0);
            checkOutput("mdl_b_valid", 32'(b_valid), (modelB.size() != 0) ? 1 : 0);
            checkOutput("mdl_a_full", 32'(a_full), (modelA.size() == DEPTH) ? 1 : 0);
            checkOutput("mdl_b_full", 32'(b_full), (modelB.size() == DEPTH) ? 1 : 0);
            checkOutput("mdl_a_count", 32'(a_count), modelACount);
            checkOutput("mdl_b_count", 32'(b_count), modelBCount);
            if (modelA.size() != 0) checkOutput("mdl_a_data", 32'(a_data), 32'(modelA[0]));
            if (modelB.size() != 0) checkOutput("mdl_b_data", 32'(b_data), 32'(modelB[0]));
            if (holdA && a_valid) checkOutput("a_data_stable", 32'(a_data), 32'(heldA));
            if (holdB && b_valid) checkOutput("b_data_stable", 32'(b_data), 32'(heldB));
        end
        holdA = a_valid && !a_ready && rst_n;
        holdB = b_valid && !b_ready && rst_n;
        heldA = a_data;
        heldB = b_data;
    end

    task automatic applyStimulus(input vec_t v);
        rst_n    = v.rstN;
        in_valid = v.inValid;
        in_sel   = v.inSel;
        in_data  = v.inData;
        a_ready  = v.aReady;
        b_ready  = v.bReady;
    endtask

    task automatic idleInputs();
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
    endtask

    initial begin
        bit lastAccepted;

        rst_n = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_a_valid", 32'(a_valid), 0);
        checkOutput("rst_b_valid", 32'(b_valid), 0);
        checkOutput("rst_a_full", 32'(a_full), 0);
        checkOutput("rst_b_full", 32'(b_full), 0);
        checkOutput("rst_a_data", 32'(a_data), 0);
        checkOutput("rst_b_data", 32'(b_data), 0);
        checkOutput("rst_a_count", 32'(a_count), 0);
        checkOutput("rst_b_count", 32'(b_count), 0);
        modelEnable = 1'b1;

        // rstN v s d ar br | ir | av ad af ac | bv bd bf bc
        vecs.push_back(mkVec(1,1,1,'hA,1,0, 1, 1,'hA,0,0, 0,0,0,0));
        vecs.push_back(mkVec(1,0,1,0,1,0,   1, 0,0,0,1,   0,0,0,0));
        vecs.push_back(mkVec(1,1,1,1,0,0,   1, 1,1,0,1,   0,0,0,0));
        vecs.push_back(mkVec(1,1,1,2,0,0,   1, 1,1,1,1,   0,0,0,0));
        vecs.push_back(mkVec(1,1,1,7,0,0,   0, 1,1,1,1,   0,0,0,0));
        vecs.push_back(mkVec(1,0,0,0,0,0,   1, 1,1,1,1,   0,0,0,0));
        vecs.push_back(mkVec(1,0,1,0,1,0,   0, 1,2,0,2,   0,0,0,0));
        vecs.push_back(mkVec(1,0,1,0,1,0,   1, 0,0,0,3,   0,0,0,0));
        vecs.push_back(mkVec(1,1,1,8,0,0,   1, 1,8,0,3,   0,0,0,0));
        vecs.push_back(mkVec(1,1,1,9,0,0,   1, 1,8,1,3,   0,0,0,0));
        vecs.push_back(mkVec(1,1,0,5,0,1,   1, 1,8,1,3,   1,5,0,0));
        vecs.push_back(mkVec(1,1,0,6,0,1,   1, 1,8,1,3,   1,6,0,1));
        vecs.push_back(mkVec(1,0,0,0,0,1,   1, 1,8,1,3,   0,0,0,2));
        vecs.push_back(mkVec(1,0,1,0,1,0,   0, 1,9,0,4,   0,0,0,2));
        vecs.push_back(mkVec(1,1,1,4,1,0,   1, 1,4,0,5,   0,0,0,2));
        vecs.push_back(mkVec(1,0,1,0,1,0,   1, 0,0,0,6,   0,0,0,2));
        vecs.push_back(mkVec(1,1,1,'hB,0,0, 1, 1,'hB,0,6, 0,0,0,2));
        vecs.push_back(mkVec(1,1,1,'hC,0,0, 1, 1,'hB,1,6, 0,0,0,2));
        vecs.push_back(mkVec(1,1,0,'hD,0,0, 1, 1,'hB,1,6, 1,'hD,0,2));
        vecs.push_back(mkVec(1,1,0,'hE,0,0, 1, 1,'hB,1,6, 1,'hD,1,2));
        vecs.push_back(mkVec(0,1,0,'hF,1,1, 0, 0,0,0,0,   0,0,0,0));
        vecs.push_back(mkVec(1,0,1,0,0,0,   1, 0,0,0,0,   0,0,0,0));
        vecs.push_back(mkVec(1,0,0,0,0,0,   1, 0,0,0,0,   0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].expInReady));
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_a_valid", i), 32'(a_valid), 32'(vecs[i].expAValid));
            checkOutput($sformatf("v%0d_a_full", i), 32'(a_full), 32'(vecs[i].expAFull));
            checkOutput($sformatf("v%0d_a_count", i), 32'(a_count), 32'(vecs[i].expACount));
            checkOutput($sformatf("v%0d_b_valid", i), 32'(b_valid), 32'(vecs[i].expBValid));
            checkOutput($sformatf("v%0d_b_full", i), 32'(b_full), 32'(vecs[i].expBFull));
            checkOutput($sformatf("v%0d_b_count", i), 32'(b_count), 32'(vecs[i].expBCount));
            if (vecs[i].expAValid)
                checkOutput($sformatf("v%0d_a_data", i), 32'(a_data), 32'(vecs[i].expAData));
            if (vecs[i].expBValid)
                checkOutput($sformatf("v%0d_b_data", i), 32'(b_data), 32'(vecs[i].expBData));
        end

        // Counter wrap: 257 words streamed through B from a cleared count.
        rst_n = 1'b1;
        idleInputs();
        b_ready  = 1'b1;
        in_sel   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_data = WIDTH'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("wrap_b_count", 32'(b_count), 1);
        checkOutput("wrap_b_valid", 32'(b_valid), 0);
        checkOutput("wrap_a_count", 32'(a_count), 0);

        // Randomized phase. A word that was offered but not taken keeps its
        // data and select until it is accepted.
        lastAccepted = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            a_ready = ($urandom_range(0, 99) < 55);
            b_ready = ($urandom_range(0, 99) < 45);
            if (lastAccepted || !in_valid || !rst_n) begin
                in_valid = ($urandom_range(0, 99) < 70);
                in_sel   = 1'($urandom);
                in_data  = WIDTH'($urandom);
            end
            @(negedge clk);
            lastAccepted = in_valid && in_ready;
            @(posedge clk);
            #1;
        end

        idleInputs();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
